mem_ctrl: RTL and testbench

Byte-serial memory controller sitting directly downstream of the CPU pipeline, between the instruction-fetch and load/store requesters and the 8-bit external memory bus. It arbitrates two requesters and splits word, halfword and byte accesses into sequential byte cycles, little-endian. It absorbs the bus's one-cycle read latency, stalls UART writes while the I/O buffer is full, and honours pipeline flushes and the global pause.

---
 rtl/mem_ctrl_if.sv | 47 ++++
 rtl/mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_if
//  Purpose  : Request/response and external byte-bus signals of mem_ctrl.
//  Revision : 1.0  initial release
// ============================================================================

interface mem_ctrl_if;
  logic        rdy_in;
  logic        flush_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [1:0]  ls_size_in;
  logic        ls_signed_in;
  logic [31:0] ls_addr_in;
  logic [31:0] ls_wdata_in;
  logic        ls_done_out;
  logic [31:0] ls_rdata_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // slave: the controller's view; master: the CPU and memory side
  modport slave (
    input  rdy_in, flush_in, if_req_in, if_addr_in,
           ls_req_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_wdata_in,
           mem_din, io_buffer_full,
    output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, flush_in, if_req_in, if_addr_in,
           ls_req_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_wdata_in,
           mem_din, io_buffer_full,
    input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           mem_dout, mem_a, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller arbitrating fetch and load/store
//             onto an 8-bit bus with one-cycle read latency.
//  Revision : 1.0  initial release
// ============================================================================

module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_in,
  mem_ctrl_if.slave bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_IF_RD = 3'd1;
  localparam logic [2:0] c_LS_RD = 3'd2;
  localparam logic [2:0] c_LS_WR = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_nbytes;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic [2:0]  r_acnt;     // byte index currently on the bus
  logic [2:0]  r_ccnt;     // bytes captured so far
  logic        r_pend;     // bus byte of last cycle is valid, data arrives now
  logic [31:0] r_buf;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic        r_if_done;
  logic [31:0] r_if_data;
  logic        r_ls_done;
  logic [31:0] r_ls_rdata;

  logic        w_ls_take;
  logic        w_if_take;
  logic [2:0]  w_req_nbytes;
  logic [2:0]  w_next_c;
  logic [2:0]  w_acnt_inc;
  logic        w_bus_ok;
  logic        w_rd_last;
  logic        w_io_stall;
  logic        w_wr_go;
  logic        w_wr_last;
  logic [31:0] w_cap_buf;
  logic [31:0] w_ext;

  always_comb begin
    // a flush cancels the speculative side, so only stores may start
    w_ls_take = bus.ls_req_in && (!bus.flush_in || bus.ls_wr_in);
    w_if_take = !w_ls_take && bus.if_req_in && !bus.flush_in;

    case (bus.ls_size_in)
      2'b00:   w_req_nbytes = 3'd1;
      2'b01:   w_req_nbytes = 3'd2;
      default: w_req_nbytes = 3'd4;
    endcase

    w_next_c   = r_ccnt + {2'b00, r_pend};
    w_acnt_inc = r_acnt + 3'd1;
    // the byte on the bus only counts if it is the next one in sequence
    w_bus_ok   = (r_acnt == w_next_c) && (r_acnt < r_nbytes);
    w_rd_last  = r_pend && (w_next_c == r_nbytes);

    w_cap_buf = r_buf;
    if (r_pend) begin
      case (r_ccnt[1:0])
        2'd0:    w_cap_buf[7:0]   = bus.mem_din;
        2'd1:    w_cap_buf[15:8]  = bus.mem_din;
        2'd2:    w_cap_buf[23:16] = bus.mem_din;
        default: w_cap_buf[31:24] = bus.mem_din;
      endcase
    end

    case (r_nbytes)
      3'd1:    w_ext = {{24{r_signed & w_cap_buf[7]}},  w_cap_buf[7:0]};
      3'd2:    w_ext = {{16{r_signed & w_cap_buf[15]}}, w_cap_buf[15:0]};
      default: w_ext = w_cap_buf;
    endcase

    w_io_stall = (r_mem_a[17:16] == 2'b11) && bus.io_buffer_full;
    w_wr_go    = bus.rdy_in && !w_io_stall;
    w_wr_last  = (w_acnt_inc == r_nbytes);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= c_IDLE;
      r_addr     <= 32'd0;
      r_nbytes   <= 3'd0;
      r_signed   <= 1'b0;
      r_wdata    <= 32'd0;
      r_acnt     <= 3'd0;
      r_ccnt     <= 3'd0;
      r_pend     <= 1'b0;
      r_buf      <= 32'd0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_done  <= 1'b0;
      r_ls_rdata <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.rdy_in && (w_ls_take || w_if_take)) begin
            r_acnt <= 3'd0;
            r_ccnt <= 3'd0;
            r_pend <= 1'b0;
            if (w_ls_take) begin
              r_addr   <= bus.ls_addr_in;
              r_nbytes <= w_req_nbytes;
              r_signed <= bus.ls_signed_in;
              r_mem_a  <= bus.ls_addr_in;
              if (bus.ls_wr_in) begin
                r_state    <= c_LS_WR;
                r_mem_wr   <= 1'b1;
                r_mem_dout <= bus.ls_wdata_in[7:0];
                r_wdata    <= bus.ls_wdata_in >> 8;
              end else begin
                r_state <= c_LS_RD;
              end
            end else begin
              r_addr   <= bus.if_addr_in;
              r_nbytes <= 3'd4;
              r_signed <= 1'b0;
              r_mem_a  <= bus.if_addr_in;
              r_state  <= c_IF_RD;
            end
          end
        end

        c_IF_RD, c_LS_RD: begin
          if (bus.flush_in) begin
            r_state <= c_IDLE;
            r_mem_a <= 32'd0;
            r_pend  <= 1'b0;
          end else if (!bus.rdy_in) begin
            // data of the byte in flight is lost; it is re-issued on resume
            r_pend <= 1'b0;
          end else if (w_rd_last) begin
            r_state <= c_DONE;
            r_mem_a <= 32'd0;
            r_pend  <= 1'b0;
            r_buf   <= w_cap_buf;
            if (r_state == c_IF_RD) begin
              r_if_done <= 1'b1;
              r_if_data <= w_cap_buf;
            end else begin
              r_ls_done  <= 1'b1;
              r_ls_rdata <= w_ext;
            end
          end else begin
            r_buf  <= w_cap_buf;
            r_ccnt <= w_next_c;
            if (w_bus_ok) begin
              r_pend <= 1'b1;
              r_acnt <= w_acnt_inc;
              if (w_acnt_inc < r_nbytes) begin
                r_mem_a <= r_addr + {29'd0, w_acnt_inc};
              end
            end else begin
              r_pend  <= 1'b0;
              r_acnt  <= w_next_c;
              r_mem_a <= r_addr + {29'd0, w_next_c};
            end
          end
        end

        c_LS_WR: begin
          if (w_wr_go) begin
            if (w_wr_last) begin
              r_state    <= c_DONE;
              r_mem_wr   <= 1'b0;
              r_mem_a    <= 32'd0;
              r_mem_dout <= 8'd0;
              r_ls_done  <= 1'b1;
              r_ls_rdata <= 32'd0;
            end else begin
              r_acnt     <= w_acnt_inc;
              r_mem_a    <= r_mem_a + 32'd1;
              r_mem_dout <= r_wdata[7:0];
              r_wdata    <= r_wdata >> 8;
            end
          end
        end

        c_DONE: begin
          if (bus.rdy_in) begin
            r_state   <= c_IDLE;
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  // pause and a full UART buffer must gate the strobe in the same cycle
  assign bus.mem_wr       = r_mem_wr && bus.rdy_in && !w_io_stall;
  assign bus.mem_a        = r_mem_a;
  assign bus.mem_dout     = r_mem_dout;
  assign bus.if_done_out  = r_if_done;
  assign bus.if_data_out  = r_if_data;
  assign bus.ls_done_out  = r_ls_done;
  assign bus.ls_rdata_out = r_ls_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Directed self-checking bench for mem_ctrl with a byte memory.
//  Revision : 1.0  initial release
// ============================================================================

module tb_mem_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_total   = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int n_if_done = 0;
  int n_ls_done = 0;
  int n_writes  = 0;
  int w0;
  int d0;

  logic [7:0] mem [bit [31:0]];
  logic [7:0] exp_wb [0:3];

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // byte memory: read data appears one cycle after its address
  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      mem[bus.mem_a] = bus.mem_dout;
      n_writes++;
    end
    if (bus.if_done_out === 1'b1) n_if_done++;
    if (bus.ls_done_out === 1'b1) n_ls_done++;
    bus.mem_din <= mem.exists(bus.mem_a) ? mem[bus.mem_a] : 8'h00;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    mem[32'h200] = 8'h80;
    mem[32'h300] = 8'h34; mem[32'h301] = 8'h92;
    mem[32'h400] = 8'h11; mem[32'h401] = 8'h22; mem[32'h402] = 8'h33; mem[32'h403] = 8'h44;
    exp_wb[0] = 8'hEF; exp_wb[1] = 8'hBE; exp_wb[2] = 8'hAD; exp_wb[3] = 8'hDE;

    bus.rdy_in = 1'b1;       bus.flush_in = 1'b0;
    bus.if_req_in = 1'b0;    bus.if_addr_in = 32'd0;
    bus.ls_req_in = 1'b0;    bus.ls_wr_in = 1'b0;
    bus.ls_size_in = 2'b00;  bus.ls_signed_in = 1'b0;
    bus.ls_addr_in = 32'd0;  bus.ls_wdata_in = 32'd0;
    bus.io_buffer_full = 1'b0;

    // reset state
    tick(2);
    chk("rst_mem_a",    bus.mem_a,        32'd0);
    chk("rst_mem_wr",   bus.mem_wr,       32'd0);
    chk("rst_mem_dout", bus.mem_dout,     32'd0);
    chk("rst_if_done",  bus.if_done_out,  32'd0);
    chk("rst_ls_done",  bus.ls_done_out,  32'd0);
    chk("rst_if_data",  bus.if_data_out,  32'd0);
    chk("rst_ls_rdata", bus.ls_rdata_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // word fetch at 0x100, request in cycle T
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_addr", bus.mem_a, 32'h100 + k);
      chk("fetch_rd",   bus.mem_wr, 32'd0);
    end
    tick();
    chk("fetch_early_done", bus.if_done_out, 32'd0);
    tick();
    chk("fetch_done", bus.if_done_out, 32'd1);
    chk("fetch_data", bus.if_data_out, 32'h0000_0513);
    bus.if_req_in = 1'b0;
    tick();
    chk("fetch_pulse_end", bus.if_done_out, 32'd0);
    chk("fetch_idle_bus",  bus.mem_a, 32'd0);

    // signed byte load of 0x80
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = 2'b00;
    bus.ls_signed_in = 1'b1; bus.ls_addr_in = 32'h200;
    tick();
    chk("lb_addr", bus.mem_a, 32'h200);
    tick();
    chk("lb_early_done", bus.ls_done_out, 32'd0);
    tick();
    chk("lb_done", bus.ls_done_out, 32'd1);
    chk("lb_data", bus.ls_rdata_out, 32'hFFFF_FF80);
    bus.ls_req_in = 1'b0;
    tick();

    // unsigned halfword load of 0x34,0x92
    bus.ls_req_in = 1'b1; bus.ls_size_in = 2'b01;
    bus.ls_signed_in = 1'b0; bus.ls_addr_in = 32'h300;
    tick(3);
    chk("lhu_early_done", bus.ls_done_out, 32'd0);
    tick();
    chk("lhu_done", bus.ls_done_out, 32'd1);
    chk("lhu_data", bus.ls_rdata_out, 32'h0000_9234);
    bus.ls_req_in = 1'b0;
    tick();

    // UART byte store with the buffer full for T+1..T+3
    w0 = n_writes;
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b00;
    bus.ls_addr_in = 32'h0003_0000; bus.ls_wdata_in = 32'hAABB_CC41;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.io_buffer_full = 1'b1;
      #1;
      chk("io_stall_wr", bus.mem_wr, 32'd0);
      chk("io_stall_a",  bus.mem_a,  32'h0003_0000);
    end
    tick();
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_wr",   bus.mem_wr,   32'd1);
    chk("io_dout", bus.mem_dout, 32'h41);
    tick();
    chk("io_done",   bus.ls_done_out,  32'd1);
    chk("io_rdata",  bus.ls_rdata_out, 32'd0);
    chk("io_nwrite", n_writes - w0,    32'd1);
    bus.ls_req_in = 1'b0;
    tick();

    // simultaneous requests: word store wins, fetch follows, then flushed
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h100;
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b10;
    bus.ls_addr_in = 32'h10; bus.ls_wdata_in = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sw_wr",   bus.mem_wr,   32'd1);
      chk("sw_addr", bus.mem_a,    32'h10 + k);
      chk("sw_dout", bus.mem_dout, {24'd0, exp_wb[k]});
    end
    tick();
    chk("sw_done",        bus.ls_done_out, 32'd1);
    chk("sw_no_if_done",  bus.if_done_out, 32'd0);
    bus.ls_req_in = 1'b0;
    d0 = n_if_done;
    tick();
    chk("arb_accept_cycle", bus.mem_a, 32'd0);
    tick();
    chk("arb_fetch_a0", bus.mem_a,  32'h100);
    chk("arb_fetch_rd", bus.mem_wr, 32'd0);
    tick();
    chk("arb_fetch_a1", bus.mem_a, 32'h101);
    bus.flush_in  = 1'b1;
    bus.if_req_in = 1'b0;
    tick();
    bus.flush_in = 1'b0;
    chk("flush_idle_bus", bus.mem_a, 32'd0);
    tick(4);
    chk("flush_no_done", n_if_done - d0, 32'd0);

    // rdy low over the first two address cycles of a word fetch
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h400;
    tick();
    bus.rdy_in = 1'b0;
    #1;
    chk("pause_a0",    bus.mem_a,  32'h400);
    chk("pause_wr",    bus.mem_wr, 32'd0);
    tick();
    chk("pause_held",  bus.mem_a,  32'h400);
    tick();
    bus.rdy_in = 1'b1;
    chk("pause_reissue", bus.mem_a, 32'h400);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("pause_addr", bus.mem_a, 32'h400 + k);
    end
    tick();
    chk("pause_early_done", bus.if_done_out, 32'd0);
    tick();
    chk("pause_done", bus.if_done_out, 32'd1);
    chk("pause_data", bus.if_data_out, 32'h4433_2211);
    bus.if_req_in = 1'b0;
    tick();

    // reset in the middle of a word store
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b10;
    bus.ls_addr_in = 32'h20; bus.ls_wdata_in = 32'h0102_0304;
    tick();
    chk("rst_st_wr", bus.mem_wr, 32'd1);
    tick();
    w0 = n_writes;
    d0 = n_ls_done;
    rst_n = 1'b0;
    #1;
    chk("rst_st_mem_wr",   bus.mem_wr,      32'd0);
    chk("rst_st_mem_a",    bus.mem_a,       32'd0);
    chk("rst_st_mem_dout", bus.mem_dout,    32'd0);
    chk("rst_st_ls_done",  bus.ls_done_out, 32'd0);
    bus.ls_req_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(4);
    chk("rst_st_no_write", n_writes - w0,  32'd0);
    chk("rst_st_no_done",  n_ls_done - d0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
